// File: rtl/led_pio_fx_pkg.sv
// +--------------------------------------------------------------------------+
// | led_pio_fx_pkg : register map and bus constants for the LED PIO          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package led_pio_fx_pkg;

    localparam int unsigned BUS_W = 32;

    localparam logic [2:0] ADDR_DATA       = 3'd0;
    localparam logic [2:0] ADDR_OUTSET     = 3'd1;
    localparam logic [2:0] ADDR_OUTCLEAR   = 3'd2;
    localparam logic [2:0] ADDR_BLINK_MASK = 3'd3;
    localparam logic [2:0] ADDR_PWM_MASK   = 3'd4;
    localparam logic [2:0] ADDR_BLINK_PER  = 3'd5;
    localparam logic [2:0] ADDR_DUTY       = 3'd6;
    localparam logic [2:0] ADDR_PRESC      = 3'd7;

endpackage

`default_nettype wire

// File: rtl/led_pio_timebase.sv
// +--------------------------------------------------------------------------+
// | led_pio_timebase : prescaler tick, PWM counter and blink phase generator |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module led_pio_timebase #(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned PRESC_W  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PRESC_W-1:0]  presc_i,
    input  logic [PRESC_W-1:0]  blink_per_i,
    input  logic [PWM_BITS-1:0] duty_i,
    input  logic                presc_clr_i,
    input  logic                blink_clr_i,
    output logic                tick_o,
    output logic                pwm_on_o,
    output logic                blink_phase_o
);

    logic [PRESC_W-1:0]  presc_cnt_q, presc_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PRESC_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;

    assign tick_o        = (presc_cnt_q == presc_i);
    assign pwm_on_o      = (pwm_cnt_q < duty_i);
    assign blink_phase_o = blink_phase_q;

    always_comb begin
        presc_cnt_d   = presc_cnt_q + PRESC_W'(1);
        pwm_cnt_d     = pwm_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;

        if (presc_clr_i || tick_o) begin
            presc_cnt_d = '0;
        end
        if (tick_o) begin
            pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        end

        // >= rather than == keeps the half-period bounded even if the count ever overshoots
        if (blink_clr_i || (blink_per_i == '0)) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (tick_o) begin
            if (blink_cnt_q >= (blink_per_i - PRESC_W'(1))) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + PRESC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_cnt_q   <= '0;
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else begin
            presc_cnt_q   <= presc_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_pio_fx.sv
// +--------------------------------------------------------------------------+
// | led_pio_fx : Avalon-MM LED port with atomic set/clear, blink and PWM     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module led_pio_fx
    import led_pio_fx_pkg::*;
#(
    parameter int unsigned       WIDTH       = 8,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter int unsigned       PWM_BITS    = 8,
    parameter int unsigned       PRESC_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [BUS_W-1:0]  writedata,
    output logic [BUS_W-1:0]  readdata,
    output logic [WIDTH-1:0]  out_port
);

    logic [WIDTH-1:0]    data_q, data_d;
    logic [WIDTH-1:0]    blink_mask_q, blink_mask_d;
    logic [WIDTH-1:0]    pwm_mask_q, pwm_mask_d;
    logic [PRESC_W-1:0]  blink_per_q, blink_per_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [WIDTH-1:0]    out_q, out_d;

    logic wr_en;
    logic presc_clr;
    logic blink_clr;
    logic tick;
    logic pwm_on;
    logic blink_phase;
    logic w_unused_bits;

    assign wr_en         = chipselect & ~write_n;
    assign w_unused_bits = ^{writedata, tick};

    always_comb begin
        data_d       = data_q;
        blink_mask_d = blink_mask_q;
        pwm_mask_d   = pwm_mask_q;
        blink_per_d  = blink_per_q;
        duty_d       = duty_q;
        presc_d      = presc_q;
        presc_clr    = 1'b0;
        blink_clr    = 1'b0;
        if (wr_en) begin
            case (address)
                ADDR_DATA:       data_d       = writedata[WIDTH-1:0];
                ADDR_OUTSET:     data_d       = data_q | writedata[WIDTH-1:0];
                ADDR_OUTCLEAR:   data_d       = data_q & ~writedata[WIDTH-1:0];
                ADDR_BLINK_MASK: blink_mask_d = writedata[WIDTH-1:0];
                ADDR_PWM_MASK:   pwm_mask_d   = writedata[WIDTH-1:0];
                ADDR_BLINK_PER: begin
                    blink_per_d = writedata[PRESC_W-1:0];
                    blink_clr   = 1'b1;
                end
                ADDR_DUTY:       duty_d       = writedata[PWM_BITS-1:0];
                ADDR_PRESC: begin
                    presc_d   = writedata[PRESC_W-1:0];
                    presc_clr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Reads come straight from the current registers, so a same-cycle write returns the old value
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:       readdata[WIDTH-1:0]    = data_q;
            ADDR_BLINK_MASK: readdata[WIDTH-1:0]    = blink_mask_q;
            ADDR_PWM_MASK:   readdata[WIDTH-1:0]    = pwm_mask_q;
            ADDR_BLINK_PER:  readdata[PRESC_W-1:0]  = blink_per_q;
            ADDR_DUTY:       readdata[PWM_BITS-1:0] = duty_q;
            ADDR_PRESC:      readdata[PRESC_W-1:0]  = presc_q;
            default: ;
        endcase
    end

    assign out_d = data_q
                 & (~blink_mask_q | {WIDTH{blink_phase}})
                 & (~pwm_mask_q   | {WIDTH{pwm_on}});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q       <= RESET_VALUE;
            blink_mask_q <= '0;
            pwm_mask_q   <= '0;
            blink_per_q  <= '0;
            duty_q       <= '0;
            presc_q      <= '0;
            out_q        <= RESET_VALUE;
        end else begin
            data_q       <= data_d;
            blink_mask_q <= blink_mask_d;
            pwm_mask_q   <= pwm_mask_d;
            blink_per_q  <= blink_per_d;
            duty_q       <= duty_d;
            presc_q      <= presc_d;
            out_q        <= out_d;
        end
    end

    assign out_port = out_q;

    led_pio_timebase #(
        .PWM_BITS (PWM_BITS),
        .PRESC_W  (PRESC_W)
    ) u_timebase (
        .clk           (clk),
        .reset_n       (reset_n),
        .presc_i       (presc_q),
        .blink_per_i   (blink_per_q),
        .duty_i        (duty_q),
        .presc_clr_i   (presc_clr),
        .blink_clr_i   (blink_clr),
        .tick_o        (tick),
        .pwm_on_o      (pwm_on),
        .blink_phase_o (blink_phase)
    );

endmodule

`default_nettype wire

// File: tb/tb_led_pio_fx.sv
// +--------------------------------------------------------------------------+
// | tb_led_pio_fx : directed self-checking bench for led_pio_fx              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_led_pio_fx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_pio_fx #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5),
        .PWM_BITS    (8),
        .PRESC_W     (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the write lands on the following rising edge
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d = readdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int n_on;
        int n_bad;

        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        chk("reset_out", {24'h0, out_port}, 32'hA5);
        rd(3'd0, v); chk("reset_data", v, 32'hA5);
        rd(3'd3, v); chk("reset_blink_mask", v, 32'h0);
        rd(3'd4, v); chk("reset_pwm_mask", v, 32'h0);
        rd(3'd5, v); chk("reset_blink_per", v, 32'h0);
        rd(3'd6, v); chk("reset_duty", v, 32'h0);
        rd(3'd7, v); chk("reset_presc", v, 32'h0);
        @(negedge clk);

        // Atomic set/clear and output latency
        wr(3'd0, 32'hF0);
        wr(3'd1, 32'h0F);
        wr(3'd2, 32'h81);
        rd(3'd0, v); chk("setclr_data", v, 32'h7E);
        chk("setclr_out_lag", {24'h0, out_port}, 32'hFF);
        @(negedge clk);
        chk("setclr_out", {24'h0, out_port}, 32'h7E);
        rd(3'd1, v); chk("outset_reads0", v, 32'h0);
        rd(3'd2, v); chk("outclear_reads0", v, 32'h0);

        // Same-cycle write returns the old value
        @(negedge clk);
        address = 3'd0; writedata = 32'h11; chipselect = 1'b1; write_n = 1'b0;
        #1;
        chk("rd_during_wr_old", readdata, 32'h7E);
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        rd(3'd0, v); chk("rd_after_wr_new", v, 32'h11);
        @(negedge clk);

        // PWM duty cycles over one full 256-tick period
        wr(3'd6, 32'd64);
        wr(3'd4, 32'hFF);
        wr(3'd0, 32'hFF);
        repeat (2) @(negedge clk);
        n_on = 0; n_bad = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (out_port == 8'hFF) n_on++;
            else if (out_port != 8'h00) n_bad++;
        end
        chk("pwm64_on_count", n_on, 64);
        chk("pwm64_bad_values", n_bad, 0);

        wr(3'd6, 32'd0);
        repeat (2) @(negedge clk);
        n_on = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (out_port != 8'h00) n_on++;
        end
        chk("pwm0_on_count", n_on, 0);

        wr(3'd6, 32'd255);
        repeat (2) @(negedge clk);
        n_on = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (out_port == 8'hFF) n_on++;
        end
        chk("pwm255_on_count", n_on, 255);

        // Blink: 4 clks per tick, 2 ticks per half-period
        wr(3'd4, 32'h00);
        wr(3'd0, 32'h01);
        wr(3'd3, 32'h01);
        wr(3'd7, 32'd3);
        wr(3'd5, 32'd2);
        for (int k = 0; k < 40; k++) begin
            if (k != 0) @(negedge clk);
            chk($sformatf("blink_k%0d", k), {24'h0, out_port},
                ((k / 8) % 2 == 0) ? 32'h01 : 32'h00);
        end

        wr(3'd5, 32'd0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("blink_off_k%0d", k), {24'h0, out_port}, 32'h01);
        end

        // Rewriting BLINK_PER mid-count restarts the half-period
        wr(3'd7, 32'd3);
        wr(3'd5, 32'd2);
        repeat (10) @(negedge clk);
        chk("restart_pre", {24'h0, out_port}, 32'h00);
        wr(3'd5, 32'd2);
        chk("restart_wr_edge", {24'h0, out_port}, 32'h00);
        for (int k = 12; k <= 20; k++) begin
            @(negedge clk);
            chk($sformatf("restart_k%0d", k), {24'h0, out_port},
                (k <= 19) ? 32'h01 : 32'h00);
        end

        // Asynchronous reset mid-blink
        #2 reset_n = 1'b0;
        #1 chk("async_reset_out", {24'h0, out_port}, 32'hA5);
        rd(3'd0, v); chk("async_reset_data", v, 32'hA5);
        rd(3'd5, v); chk("async_reset_blink_per", v, 32'h0);
        rd(3'd3, v); chk("async_reset_blink_mask", v, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        wr(3'd4, 32'hFF);
        wr(3'd6, 32'd20);
        wr(3'd0, 32'hFF);
        chk("post_reset_k3", {24'h0, out_port}, 32'hA5);
        for (int k = 4; k <= 22; k++) begin
            @(negedge clk);
            chk($sformatf("post_reset_pwm_k%0d", k), {24'h0, out_port},
                (k <= 20) ? 32'hFF : 32'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
